// File: rtl/eviction_allocator.sv
// rtl/eviction_allocator.sv - miss-side way allocator for the eviction policy interface
// Picks a fill way, issues dirty-victim writebacks and keeps hit/allocate apart at the policy.
module eviction_allocator #(
  parameter int NUM_WAYS    = 4,
  parameter int MAX_RETRIES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                missValid,
  output logic                missReady,
  input  logic [NUM_WAYS-1:0] validWays,
  input  logic [NUM_WAYS-1:0] dirtyWays,
  input  logic [NUM_WAYS-1:0] lookupHit,
  output logic                lookupReady,
  output logic [NUM_WAYS-1:0] hitWay,
  output logic [NUM_WAYS-1:0] allocateWay,
  output logic                evictReq,
  input  logic [NUM_WAYS-1:0] evictionTarget,
  input  logic                evictionReady,
  output logic                wbValid,
  output logic [NUM_WAYS-1:0] wbWay,
  input  logic                wbReady,
  output logic                allocDone,
  output logic                protocolError
);

  localparam int CW = $clog2(MAX_RETRIES + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE, SELECT, REQ_POLICY, RETRY, WRITEBACK, ALLOCATE
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_WAYS-1:0] victim_q, victim_d;
  logic [NUM_WAYS-1:0] valid_q, valid_d;
  logic [NUM_WAYS-1:0] dirty_q, dirty_d;
  logic [CW-1:0]       retry_q, retry_d;

  logic [NUM_WAYS-1:0] first_invalid;
  logic [NUM_WAYS-1:0] fallback_way;
  logic                target_onehot;
  logic [CW-1:0]       retry_inc;

  always_comb begin
    first_invalid = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        first_invalid    = '0;
        first_invalid[i] = 1'b1;
      end
    end
    fallback_way               = '0;
    fallback_way[NUM_WAYS-1]   = 1'b1;
    target_onehot = (evictionTarget != '0) &&
                    ((evictionTarget & (evictionTarget - NUM_WAYS'(1))) == '0);
    retry_inc = (retry_q == MAX_CNT) ? retry_q : retry_q + CW'(1);
  end

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    retry_d       = retry_q;
    missReady     = 1'b0;
    evictReq      = 1'b0;
    wbValid       = 1'b0;
    wbWay         = '0;
    allocateWay   = '0;
    allocDone     = 1'b0;
    protocolError = 1'b0;
    lookupReady   = (state_q != ALLOCATE);

    case (state_q)
      IDLE: begin
        missReady = 1'b1;
        if (missValid) begin
          valid_d = validWays;
          dirty_d = dirtyWays;
          retry_d = '0;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (!(&valid_q)) begin
          victim_d = first_invalid;
          state_d  = ALLOCATE;
        end else begin
          state_d = REQ_POLICY;
        end
      end
      REQ_POLICY: begin
        evictReq = 1'b1;
        if (evictionReady) begin
          if (target_onehot) begin
            victim_d = evictionTarget;
            state_d  = |(evictionTarget & dirty_q) ? WRITEBACK : ALLOCATE;
          end else begin
            protocolError = 1'b1;
            retry_d       = retry_inc;
            if (retry_inc < MAX_CNT) begin
              state_d = RETRY;
            end else begin
              // Out of retries: evict the highest way rather than stall the miss.
              victim_d = fallback_way;
              state_d  = dirty_q[NUM_WAYS-1] ? WRITEBACK : ALLOCATE;
            end
          end
        end
      end
      RETRY: state_d = REQ_POLICY;
      WRITEBACK: begin
        wbValid = 1'b1;
        wbWay   = victim_q;
        if (wbReady) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        allocateWay = victim_q;
        allocDone   = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    hitWay = lookupReady ? lookupHit : '0;

    if (reset) begin
      missReady     = 1'b0;
      lookupReady   = 1'b0;
      hitWay        = '0;
      evictReq      = 1'b0;
      wbValid       = 1'b0;
      wbWay         = '0;
      allocateWay   = '0;
      allocDone     = 1'b0;
      protocolError = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      victim_q <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      retry_q  <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      retry_q  <= retry_d;
    end
  end

endmodule

// File: tb/tb_eviction_allocator.sv
// tb/tb_eviction_allocator.sv - scoreboard bench for eviction_allocator
module tb_eviction_allocator;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         missValid = 1'b0;
  logic         missReady;
  logic [N-1:0] validWays = '0;
  logic [N-1:0] dirtyWays = '0;
  logic [N-1:0] lookupHit = '0;
  logic         lookupReady;
  logic [N-1:0] hitWay;
  logic [N-1:0] allocateWay;
  logic         evictReq;
  logic [N-1:0] evictionTarget = '0;
  logic         evictionReady = 1'b0;
  logic         wbValid;
  logic [N-1:0] wbWay;
  logic         wbReady = 1'b0;
  logic         allocDone;
  logic         protocolError;

  eviction_allocator #(.NUM_WAYS(N), .MAX_RETRIES(3)) dut (
    .clk(clk), .reset(reset), .missValid(missValid), .missReady(missReady),
    .validWays(validWays), .dirtyWays(dirtyWays), .lookupHit(lookupHit),
    .lookupReady(lookupReady), .hitWay(hitWay), .allocateWay(allocateWay),
    .evictReq(evictReq), .evictionTarget(evictionTarget),
    .evictionReady(evictionReady), .wbValid(wbValid), .wbWay(wbWay),
    .wbReady(wbReady), .allocDone(allocDone), .protocolError(protocolError)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] way;
    int           cyc;
  } exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_bad = 0;
  bit ev_seen = 0;
  bit wb_seen = 0;
  int perr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (evictReq) ev_seen = 1;
      if (wbValid) wb_seen = 1;
      if (protocolError) perr_cnt++;
      if (allocDone) begin
        if (q.size() == 0) begin
          check("unexpected_alloc", 32'(allocDone), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("alloc_way", 32'(allocateWay), 32'(e.way));
          check("alloc_cycle", 32'(cyc), 32'(e.cyc));
          check("alloc_hit_excl", 32'(hitWay), 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_alloc(input logic [N-1:0] way, input int c);
    exp_t e;
    e.way = way;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic miss(input logic [N-1:0] v, input logic [N-1:0] d, output int a);
    a = cyc;
    missValid = 1'b1;
    validWays = v;
    dirtyWays = d;
    tick();
    missValid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    check("queue_drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int a;
    reset = 1'b1;
    lookupHit = 4'b0001;
    repeat (3) tick();
    @(negedge clk);
    check("rst_missReady", 32'(missReady), 32'd0);
    check("rst_lookupReady", 32'(lookupReady), 32'd0);
    check("rst_hitWay", 32'(hitWay), 32'd0);
    check("rst_allocateWay", 32'(allocateWay), 32'd0);
    check("rst_evictReq", 32'(evictReq), 32'd0);
    check("rst_wbValid", 32'(wbValid), 32'd0);
    check("rst_wbWay", 32'(wbWay), 32'd0);
    check("rst_allocDone", 32'(allocDone), 32'd0);
    check("rst_protocolError", 32'(protocolError), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_missReady", 32'(missReady), 32'd1);
    check("post_rst_lookupReady", 32'(lookupReady), 32'd1);
    check("post_rst_hitWay", 32'(hitWay), 32'b0001);
    lookupHit = '0;

    // invalid way present
    ev_seen = 0;
    miss(4'b1011, 4'b0000, a);
    expect_alloc(4'b0100, a + 2);
    go_to(a + 3);
    @(negedge clk);
    check("inv_missReady_c3", 32'(missReady), 32'd1);
    wait_empty();
    check("inv_no_evictReq", 32'(ev_seen), 32'd0);

    // clean policy victim, response three cycles after evictReq
    wb_seen = 0;
    miss(4'b1111, 4'b0000, a);
    go_to(a + 2);
    @(negedge clk);
    check("clean_evictReq_c2", 32'(evictReq), 32'd1);
    go_to(a + 5);
    evictionReady = 1'b1;
    evictionTarget = 4'b1000;
    expect_alloc(4'b1000, a + 6);
    tick();
    evictionReady = 1'b0;
    evictionTarget = '0;
    wait_empty();
    check("clean_no_wb", 32'(wb_seen), 32'd0);

    // dirty victim, response on the first evictReq cycle, wbReady held off 4 cycles
    miss(4'b1111, 4'b0010, a);
    go_to(a + 2);
    evictionReady = 1'b1;
    evictionTarget = 4'b0010;
    tick();
    evictionReady = 1'b0;
    evictionTarget = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("dirty_wbValid", 32'(wbValid), 32'd1);
      check("dirty_wbWay", 32'(wbWay), 32'b0010);
      tick();
    end
    wbReady = 1'b1;
    expect_alloc(4'b0010, a + 8);
    tick();
    wbReady = 1'b0;
    wait_empty();

    // three bad responses -> fallback to highest way
    perr_cnt = 0;
    miss(4'b1111, 4'b0000, a);
    go_to(a + 2);
    evictionReady = 1'b1;
    evictionTarget = 4'b0000;
    tick();
    evictionReady = 1'b0;
    @(negedge clk);
    check("bad_retry1_evictReq", 32'(evictReq), 32'd0);
    tick();
    evictionReady = 1'b1;
    evictionTarget = 4'b0110;
    tick();
    evictionReady = 1'b0;
    @(negedge clk);
    check("bad_retry2_evictReq", 32'(evictReq), 32'd0);
    tick();
    evictionReady = 1'b1;
    evictionTarget = 4'b0110;
    expect_alloc(4'b1000, a + 7);
    tick();
    evictionReady = 1'b0;
    evictionTarget = '0;
    wait_empty();
    check("bad_perr_count", 32'(perr_cnt), 32'd3);

    // hit held across the ALLOCATE cycle
    miss(4'b0111, 4'b0000, a);
    expect_alloc(4'b1000, a + 2);
    lookupHit = 4'b0001;
    @(negedge clk);
    check("hit_before_alloc", 32'(hitWay), 32'b0001);
    tick();
    @(negedge clk);
    check("hit_alloc_lookupReady", 32'(lookupReady), 32'd0);
    check("hit_alloc_hitWay", 32'(hitWay), 32'd0);
    tick();
    @(negedge clk);
    check("hit_after_alloc", 32'(hitWay), 32'b0001);
    lookupHit = '0;
    wait_empty();

    // reset during writeback
    miss(4'b1111, 4'b1111, a);
    go_to(a + 2);
    evictionReady = 1'b1;
    evictionTarget = 4'b0100;
    tick();
    evictionReady = 1'b0;
    evictionTarget = '0;
    @(negedge clk);
    check("rstwb_wbValid_before", 32'(wbValid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rstwb_wbValid_after", 32'(wbValid), 32'd0);
    check("rstwb_allocateWay", 32'(allocateWay), 32'd0);
    check("rstwb_missReady", 32'(missReady), 32'd1);

    // missValid outside IDLE is dropped, not queued
    miss(4'b1110, 4'b0000, a);
    expect_alloc(4'b0001, a + 2);
    missValid = 1'b1;
    validWays = 4'b0000;
    tick();
    tick();
    missValid = 1'b0;
    repeat (4) @(negedge clk);
    wait_empty();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
